input_conditioner: RTL and testbench

- Conditions the raw board inputs (push-button key, 17 slide switches) before they reach the processor's button/switches inputs.
- Synchronises both inputs into the board clock domain and debounces the key.
- On each debounced press, emits a one-cycle pulse and latches the switch value as an input word.
- Holds that word under a valid/ack handshake until the processor's input instruction consumes it.

---
 rtl/input_conditioner.sv | 151 +++++++++++++++
 tb/tb_input_conditioner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner
//   Conditions the raw board inputs before they reach the processor:
//   synchronises the active-low key and the slide switches, debounces the
//   key, and on each accepted press latches the switch word and holds it
//   under a valid/ack handshake until the consumer takes it.
//
// Ports:
//   clock            board clock (only clock in the block)
//   reset            asynchronous, active-high reset
//   button_raw       raw key, active-low (0 = pressed)
//   switches_raw     raw slide switches
//   input_ack        consumer has taken the latched word
//   button_pulse     one-cycle strobe per accepted press
//   button_level     debounced key state, 1 = pressed
//   switches_sync    synchronised (not debounced) switches
//   switches_latched switch word captured at the last accepted press
//   input_valid      switches_latched holds an unconsumed word
//   dropped_count    presses lost while a word was pending, saturating
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter int SW_WIDTH        = 17
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                button_raw,
    input  logic [SW_WIDTH-1:0] switches_raw,
    input  logic                input_ack,
    output logic                button_pulse,
    output logic                button_level,
    output logic [SW_WIDTH-1:0] switches_sync,
    output logic [SW_WIDTH-1:0] switches_latched,
    output logic                input_valid,
    output logic [7:0]          dropped_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0]               key_sync;
    logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    logic             pressed;
    logic             latch_en;
    logic             drop;
    logic             valid_next;

    assign pressed       = ~key_sync[SYNC_STAGES-1];
    assign switches_sync = sw_sync[SYNC_STAGES-1];

    // Debounce next-state logic; accept marks the edge that raises button_pulse.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Handshake: a press arriving with ack on the same edge is accepted,
    // since the pending word is being consumed at that very edge.
    always_comb begin
        latch_en   = accept && (!input_valid || input_ack);
        drop       = accept && input_valid && !input_ack;
        valid_next = input_valid;
        if (accept) begin
            valid_next = 1'b1;
        end else if (input_ack) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_sync         <= '1;
            sw_sync          <= '0;
            state            <= IDLE;
            cnt              <= '0;
            button_pulse     <= 1'b0;
            button_level     <= 1'b0;
            switches_latched <= '0;
            input_valid      <= 1'b0;
            dropped_count    <= '0;
        end else begin
            key_sync     <= {key_sync[SYNC_STAGES-2:0], button_raw};
            sw_sync      <= {sw_sync[SYNC_STAGES-2:0], switches_raw};
            state        <= state_next;
            cnt          <= cnt_next;
            button_pulse <= accept;
            button_level <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
            if (latch_en) begin
                switches_latched <= switches_sync;
            end
            input_valid <= valid_next;
            if (drop && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4 and
//   SYNC_STAGES = 2. Each press pushes its expected handshake result into a
//   scoreboard queue; a monitor pops and compares whenever button_pulse is seen.
module tb_input_conditioner;

    localparam int SW = 17;

    logic          clock = 1'b0;
    logic          reset;
    logic          button_raw;
    logic [SW-1:0] switches_raw;
    logic          input_ack;
    logic          button_pulse;
    logic          button_level;
    logic [SW-1:0] switches_sync;
    logic [SW-1:0] switches_latched;
    logic          input_valid;
    logic [7:0]    dropped_count;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .SW_WIDTH       (SW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .button_raw      (button_raw),
        .switches_raw    (switches_raw),
        .input_ack       (input_ack),
        .button_pulse    (button_pulse),
        .button_level    (button_level),
        .switches_sync   (switches_sync),
        .switches_latched(switches_latched),
        .input_valid     (input_valid),
        .dropped_count   (dropped_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [SW-1:0] latched;
        logic          valid;
        logic [7:0]    dropped;
    } exp_t;

    typedef struct {
        logic [SW-1:0] sw;
        logic          ack;
        logic [SW-1:0] exp_latched;
        logic          exp_valid;
        logic [7:0]    exp_dropped;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (button_pulse) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got button_pulse=1 required 0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_latched", 32'(switches_latched), 32'(e.latched));
                check("pulse_valid",   32'(input_valid),      32'(e.valid));
                check("pulse_dropped", 32'(dropped_count),    32'(e.dropped));
                check("pulse_level",   32'(button_level),     32'd1);
            end
        end
    end

    // Waits for the acceptance edge, counting rising edges from the caller's
    // drive point; optionally raises input_ack so it is sampled on edge 7.
    task automatic wait_accept(input logic ack_acc);
        int  edges = 0;
        logic got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clock);
            #1;
            if (button_pulse) begin
                got   = 1'b1;
                edges = i;
                input_ack = 1'b0;
            end else if (ack_acc && i == 6) begin
                input_ack = 1'b1;
            end
        end
        input_ack = 1'b0;
        check("accept_latency", 32'(edges), 32'd7);
        @(posedge clock);
        #1;
        check("pulse_one_cycle", 32'(button_pulse), 32'd0);
    endtask

    task automatic release_key();
        logic got = 1'b0;
        @(negedge clock);
        button_raw = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clock);
            #1;
            if (!button_level) got = 1'b1;
        end
        check("release_done", 32'(got), 32'd1);
    endtask

    task automatic press(input logic [SW-1:0] sw, input logic ack_acc, input exp_t e);
        sb_q.push_back(e);
        @(negedge clock);
        switches_raw = sw;
        button_raw   = 1'b0;
        wait_accept(ack_acc);
        release_key();
    endtask

    vec_t vecs[6];

    initial begin
        exp_t e;
        logic saw;
        int   exp_drop;

        vecs[0] = '{sw: 17'h1A5A5, ack: 1'b0, exp_latched: 17'h1A5A5, exp_valid: 1'b1, exp_dropped: 8'd0};
        vecs[1] = '{sw: 17'h1A5A5, ack: 1'b0, exp_latched: 17'h1A5A5, exp_valid: 1'b1, exp_dropped: 8'd0};
        vecs[2] = '{sw: 17'h0FFFF, ack: 1'b0, exp_latched: 17'h1A5A5, exp_valid: 1'b1, exp_dropped: 8'd1};
        vecs[3] = '{sw: 17'h00000, ack: 1'b0, exp_latched: 17'h1A5A5, exp_valid: 1'b1, exp_dropped: 8'd2};
        vecs[4] = '{sw: 17'h15555, ack: 1'b0, exp_latched: 17'h1A5A5, exp_valid: 1'b1, exp_dropped: 8'd3};
        vecs[5] = '{sw: 17'h00003, ack: 1'b1, exp_latched: 17'h00003, exp_valid: 1'b1, exp_dropped: 8'd3};

        reset        = 1'b1;
        button_raw   = 1'b1;
        switches_raw = 17'h1FFFF;
        input_ack    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pulse",   32'(button_pulse),     32'd0);
        check("rst_level",   32'(button_level),     32'd0);
        check("rst_sync",    32'(switches_sync),    32'd0);
        check("rst_latched", 32'(switches_latched), 32'd0);
        check("rst_valid",   32'(input_valid),      32'd0);
        check("rst_dropped", 32'(dropped_count),    32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("sw_sync_follow", 32'(switches_sync), 32'h1FFFF);

        // Bounce shorter than the debounce window: no pulse, level stays low.
        saw = 1'b0;
        @(negedge clock); button_raw = 1'b0;
        repeat (3) @(negedge clock); button_raw = 1'b1;
        repeat (2) @(negedge clock); button_raw = 1'b0;
        repeat (2) @(negedge clock); button_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (button_level || button_pulse) saw = 1'b1;
        end
        check("bounce_quiet", 32'(saw), 32'd0);

        // Clean press into an empty latch.
        e = '{latched: vecs[0].exp_latched, valid: vecs[0].exp_valid, dropped: vecs[0].exp_dropped};
        press(vecs[0].sw, vecs[0].ack, e);

        // Ack clears valid on its edge; the word stays latched.
        @(negedge clock); input_ack = 1'b1;
        @(posedge clock);
        #1;
        check("ack_valid",   32'(input_valid),      32'd0);
        check("ack_latched", 32'(switches_latched), 32'h1A5A5);
        @(negedge clock); input_ack = 1'b0;
        // Ack with nothing pending changes nothing.
        @(negedge clock); input_ack = 1'b1;
        @(posedge clock);
        #1;
        check("idle_ack_valid",   32'(input_valid),      32'd0);
        check("idle_ack_latched", 32'(switches_latched), 32'h1A5A5);
        @(negedge clock); input_ack = 1'b0;

        // Refill, then drops while pending, then a press coinciding with ack.
        for (int i = 1; i < 6; i++) begin
            e = '{latched: vecs[i].exp_latched, valid: vecs[i].exp_valid, dropped: vecs[i].exp_dropped};
            press(vecs[i].sw, vecs[i].ack, e);
        end
        check("simul_latched", 32'(switches_latched), 32'h00003);
        check("simul_dropped", 32'(dropped_count),    32'd3);

        // Saturation of dropped_count.
        exp_drop = 3;
        for (int i = 0; i < 300; i++) begin
            exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
            e = '{latched: 17'h00003, valid: 1'b1, dropped: 8'(exp_drop)};
            press(17'($urandom), 1'b0, e);
        end
        check("sat_dropped", 32'(dropped_count),    32'd255);
        check("sat_latched", 32'(switches_latched), 32'h00003);
        check("pre_rst_valid", 32'(input_valid),    32'd1);

        // Reset in PRESS_WAIT with cnt = 2 (after edge 5 of a held press).
        @(negedge clock);
        switches_raw = 17'h0ABCD;
        button_raw   = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pulse",   32'(button_pulse),     32'd0);
        check("arst_level",   32'(button_level),     32'd0);
        check("arst_sync",    32'(switches_sync),    32'd0);
        check("arst_latched", 32'(switches_latched), 32'd0);
        check("arst_valid",   32'(input_valid),      32'd0);
        check("arst_dropped", 32'(dropped_count),    32'd0);
        @(posedge clock);
        sb_q.push_back('{latched: 17'h0ABCD, valid: 1'b1, dropped: 8'd0});
        @(negedge clock);
        reset = 1'b0;
        wait_accept(1'b0);
        release_key();

        repeat (3) @(posedge clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
